// File: rtl/cla_addsub_pipe_if.sv
// Handshake and data bundle for the pipelined CLA add/sub/compare unit.
// The slave modport is the execute-unit side. The master modport is the
// producer/consumer side that drives operands and accepts results.
interface cla_addsub_pipe_if #(
    parameter int XLEN = 32
) ();
    logic            In_Valid;
    logic            In_Ready;
    logic [XLEN-1:0] Rs1;
    logic [XLEN-1:0] Rs2;
    logic [1:0]      Op;
    logic            Out_Valid;
    logic            Out_Ready;
    logic [XLEN-1:0] Result;
    logic            Carry_Out;
    logic            Overflow;
    logic            Zero;

    modport slave (
        input  In_Valid,
        output In_Ready,
        input  Rs1,
        input  Rs2,
        input  Op,
        output Out_Valid,
        input  Out_Ready,
        output Result,
        output Carry_Out,
        output Overflow,
        output Zero
    );

    modport master (
        output In_Valid,
        input  In_Ready,
        output Rs1,
        output Rs2,
        output Op,
        input  Out_Valid,
        output Out_Ready,
        input  Result,
        input  Carry_Out,
        input  Overflow,
        input  Zero
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor/comparator.
// An XLEN-bit operation is split into STAGES = XLEN/BLOCK slices. Stage k adds
// bits [k*BLOCK +: BLOCK] using the carry registered by stage k-1. The operands,
// the opcode and the finished low result bits travel forward with the carry.
// The last stage forms the Result and flags directly into the output registers.
// The whole pipeline stalls as one unit whenever a valid output is not accepted.
module cla_addsub_pipe #(
    parameter int XLEN  = 32,
    parameter int BLOCK = 8
) (
    input  logic              CLK,
    input  logic              rst,
    cla_addsub_pipe_if.slave  bus
);
    localparam int STAGES = XLEN / BLOCK;
    localparam int LAST   = STAGES - 1;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SLT  = 2'b10;
    localparam logic [1:0] OP_SLTU = 2'b11;

    // One lookahead slice. The return value is packed as
    // {carry out, carry into slice MSB, sum}. Every carry is expanded as a flat
    // generate/propagate product, so no carry waits on the carry below it.
    function automatic logic [BLOCK+1:0] cla_slice(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             cin
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] sum;
        logic [BLOCK:0]   c;
        logic             gg;
        logic             pp;
        g    = a & b;
        p    = a | b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int j = i; j >= 0; j--) begin
                gg = gg | (g[j] & pp);
                pp = pp & p[j];
            end
            c[i+1] = gg | (pp & cin);
        end
        sum = a ^ b ^ c[BLOCK-1:0];
        return {c[BLOCK], c[BLOCK-1], sum};
    endfunction

    // Inter-stage registers. Entry k holds what stage k produced.
    // Only entries 0..LAST-1 carry data; the last stage writes the output registers.
    logic            valid_r [STAGES];
    logic [XLEN-1:0] a_r     [STAGES];
    logic [XLEN-1:0] b_r     [STAGES];
    logic [XLEN-1:0] sum_r   [STAGES];
    logic            c_r     [STAGES];
    logic [1:0]      op_r    [STAGES];

    // Per-stage combinational view.
    logic [XLEN-1:0]  a_in_s   [STAGES];
    logic [XLEN-1:0]  b_in_s   [STAGES];
    logic [XLEN-1:0]  sum_in_s [STAGES];
    logic             c_in_s   [STAGES];
    logic [1:0]       op_in_s  [STAGES];
    logic [BLOCK+1:0] slice_s  [STAGES];
    logic [XLEN-1:0]  sum_nx_s [STAGES];

    logic             adv_s;
    logic             vld_last_in_s;
    logic             carry_s;
    logic             cm_s;
    logic             v_s;
    logic             n_s;
    logic [XLEN-1:0]  res_s;

    logic [XLEN-1:0]  result_r;
    logic             carry_out_r;
    logic             overflow_r;
    logic             zero_r;

    assign adv_s         = ~valid_r[LAST] | bus.Out_Ready;
    assign bus.In_Ready  = adv_s;
    assign bus.Out_Valid = valid_r[LAST];
    assign bus.Result    = result_r;
    assign bus.Carry_Out = carry_out_r;
    assign bus.Overflow  = overflow_r;
    assign bus.Zero      = zero_r;

    // The input valid for the last stage. It is In_Valid when there is a single stage.
    if (STAGES > 1) begin : g_vld_multi
        assign vld_last_in_s = valid_r[LAST-1];
    end else begin : g_vld_single
        assign vld_last_in_s = bus.In_Valid;
    end

    // Select each stage's inputs. Stage 0 takes the ports and folds in the subtract
    // inversion and carry-in. Later stages take the registers of the stage below.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            a_in_s[k]   = '0;
            b_in_s[k]   = '0;
            sum_in_s[k] = '0;
            c_in_s[k]   = 1'b0;
            op_in_s[k]  = OP_ADD;
        end
        a_in_s[0]  = bus.Rs1;
        op_in_s[0] = bus.Op;
        if (bus.Op == OP_ADD) begin
            b_in_s[0] = bus.Rs2;
            c_in_s[0] = 1'b0;
        end else begin
            b_in_s[0] = ~bus.Rs2;
            c_in_s[0] = 1'b1;
        end
        for (int k = 1; k < STAGES; k++) begin
            a_in_s[k]   = a_r[k-1];
            b_in_s[k]   = b_r[k-1];
            sum_in_s[k] = sum_r[k-1];
            c_in_s[k]   = c_r[k-1];
            op_in_s[k]  = op_r[k-1];
        end
    end

    // Each stage adds its own slice and merges it into the partial sum it received.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            slice_s[k]  = cla_slice(a_in_s[k][k*BLOCK +: BLOCK],
                                    b_in_s[k][k*BLOCK +: BLOCK],
                                    c_in_s[k]);
            sum_nx_s[k] = sum_in_s[k];
            sum_nx_s[k][k*BLOCK +: BLOCK] = slice_s[k][BLOCK-1:0];
        end
    end

    // Last-stage flag and result formation from the completed raw sum.
    always_comb begin
        carry_s = slice_s[LAST][BLOCK+1];
        cm_s    = slice_s[LAST][BLOCK];
        v_s     = carry_s ^ cm_s;
        n_s     = sum_nx_s[LAST][XLEN-1];
        case (op_in_s[LAST])
            OP_ADD:  res_s = sum_nx_s[LAST];
            OP_SUB:  res_s = sum_nx_s[LAST];
            OP_SLT:  res_s = {{(XLEN-1){1'b0}}, n_s ^ v_s};
            OP_SLTU: res_s = {{(XLEN-1){1'b0}}, ~carry_s};
            default: res_s = sum_nx_s[LAST];
        endcase
    end

    // Valid bits shift together on every advance. Bubbles shift too and are never squeezed out.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_r[k] <= 1'b0;
            end
        end else if (adv_s) begin
            valid_r[0] <= bus.In_Valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_r[k] <= valid_r[k-1];
            end
        end
    end

    // Intermediate data registers. Their contents are don't-care behind a bubble.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LAST; k++) begin
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                sum_r[k] <= '0;
                c_r[k]   <= 1'b0;
                op_r[k]  <= OP_ADD;
            end
        end else if (adv_s) begin
            for (int k = 0; k < LAST; k++) begin
                a_r[k]   <= a_in_s[k];
                b_r[k]   <= b_in_s[k];
                sum_r[k] <= sum_nx_s[k];
                c_r[k]   <= slice_s[k][BLOCK+1];
                op_r[k]  <= op_in_s[k];
            end
        end
    end

    // Output registers. They load only with a real operation, so a bubble leaves the last result visible.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            result_r    <= '0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
        end else if (adv_s && vld_last_in_s) begin
            result_r    <= res_s;
            carry_out_r <= carry_s;
            overflow_r  <= v_s;
            zero_r      <= (res_s == {XLEN{1'b0}});
        end
    end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe. Expected values come from hand constants
// or from a plain-arithmetic reference model. A scoreboard queue checks order,
// latency and the absence of lost or duplicated results.
module tb_cla_addsub_pipe;
    localparam int XLEN   = 32;
    localparam int BLOCK  = 8;
    localparam int STAGES = XLEN / BLOCK;

    logic CLK = 1'b0;
    logic rst;

    always #5 CLK = ~CLK;

    cla_addsub_pipe_if #(.XLEN(XLEN)) bus ();

    cla_addsub_pipe #(.XLEN(XLEN), .BLOCK(BLOCK)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [34:0] exp;
        int          t;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_out   = 0;
    bit          lat_chk = 1'b0;
    logic [34:0] cur_exp;

    // Count one comparison and report it if the values differ.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: {carry, overflow, zero, result} from plain arithmetic.
    function automatic logic [34:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        logic [32:0] w;
        logic [31:0] r;
        logic        v;
        if (op == 2'b00) begin
            w = {1'b0, a} + {1'b0, b};
            v = (a[31] == b[31]) && (w[31] != a[31]);
        end else begin
            w = {1'b0, a} + {1'b0, ~b} + 33'd1;
            v = (a[31] != b[31]) && (w[31] != a[31]);
        end
        case (op)
            2'b10:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            2'b11:   r = (a < b) ? 32'd1 : 32'd0;
            default: r = w[31:0];
        endcase
        return {w[32], v, (r == 32'd0), r};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [34:0] exp);
        bus.Rs1      = a;
        bus.Rs2      = b;
        bus.Op       = op;
        bus.In_Valid = 1'b1;
        cur_exp      = exp;
    endtask

    task automatic drive_rand();
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        a  = pick_operand();
        b  = pick_operand();
        op = 2'($urandom_range(0, 3));
        drive(a, b, op, ref_model(a, b, op));
    endtask

    // Called just after a falling edge with inputs set. It samples, scores and advances one cycle.
    task automatic tick();
        exp_t e;
        #1;
        if (bus.Out_Valid && bus.Out_Ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check_val("spurious_out", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_val("result", {29'd0, bus.Carry_Out, bus.Overflow, bus.Zero, bus.Result}, {29'd0, e.exp});
                if (lat_chk) check_val("latency", 64'(cyc - e.t), 64'(STAGES));
            end
        end
        if (bus.In_Valid && bus.In_Ready) begin
            e.exp = cur_exp;
            e.t   = cyc;
            sb.push_back(e);
        end
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && sb.size() > 0; i++) tick();
        check_val("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                              input logic [34:0] exp);
        drive(a, b, op, exp);
        tick();
        bus.In_Valid = 1'b0;
        drain(12);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_out_valid"}, 64'(bus.Out_Valid), 64'd0);
        check_val({tag, "_result"},    64'(bus.Result),    64'd0);
        check_val({tag, "_flags"},     {61'd0, bus.Carry_Out, bus.Overflow, bus.Zero}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst           = 1'b1;
        bus.In_Valid  = 1'b0;
        bus.Out_Ready = 1'b1;
        bus.Rs1       = '0;
        bus.Rs2       = '0;
        bus.Op        = 2'b00;
        cur_exp       = '0;
        #1;
        check_reset_outputs("reset");
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        rst = 1'b0;
        #1;
        check_val("in_ready_after_reset", 64'(bus.In_Ready), 64'd1);

        // Directed corner cases. Expected values are worked out by hand.
        lat_chk = 1'b1;
        run_single(32'h7FFF_FFFF, 32'h0000_0001, 2'b00, {1'b0, 1'b1, 1'b0, 32'h8000_0000});
        run_single(32'h0000_0005, 32'h0000_0005, 2'b01, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
        run_single(32'h0000_0000, 32'h0000_0001, 2'b01, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF});
        run_single(32'hFFFF_FFFF, 32'h0000_0001, 2'b10, {1'b1, 1'b0, 1'b0, 32'h0000_0001});
        run_single(32'hFFFF_FFFF, 32'h0000_0001, 2'b11, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
        run_single(32'h8000_0000, 32'h7FFF_FFFF, 2'b10, {1'b1, 1'b1, 1'b0, 32'h0000_0001});

        // Back-to-back stream of 16 random operations.
        base = n_out;
        for (int i = 0; i < 16; i++) begin
            drive_rand();
            tick();
        end
        bus.In_Valid = 1'b0;
        drain(20);
        check_val("stream_count", 64'(n_out - base), 64'd16);

        // Back-pressure with a full pipeline.
        lat_chk = 1'b0;
        base    = n_out;
        for (int i = 0; i < STAGES; i++) begin
            drive_rand();
            tick();
        end
        bus.Out_Ready = 1'b0;
        drive_rand();
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("stall_in_ready", 64'(bus.In_Ready), 64'd0);
            check_val("stall_out_valid", 64'(bus.Out_Valid), 64'd1);
            if (sb.size() > 0)
                check_val("stall_hold", {29'd0, bus.Carry_Out, bus.Overflow, bus.Zero, bus.Result},
                          {29'd0, sb[0].exp});
            tick();
        end
        check_val("stall_no_accept", 64'(sb.size()), 64'(STAGES));
        bus.Out_Ready = 1'b1;
        tick();
        bus.In_Valid = 1'b0;
        drain(20);
        check_val("stall_count", 64'(n_out - base), 64'(STAGES + 1));

        // Reset with three operations in flight.
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            tick();
        end
        bus.In_Valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        @(posedge CLK);
        @(negedge CLK);
        rst = 1'b0;
        #1;
        check_val("in_ready_after_midreset", 64'(bus.In_Ready), 64'd1);
        base = n_out;
        for (int i = 0; i < 8; i++) tick();
        check_val("stale_valid", 64'(n_out - base), 64'd0);
        run_single(32'h1234_5678, 32'h0000_1111, 2'b00, {1'b0, 1'b0, 1'b0, 32'h1234_6789});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
